keypad_scan: RTL and testbench
==============================

Name: keypad_scan

Overview:
Scans a 4x4 active-low matrix keypad and debounces the key presses. Each accepted key becomes a 4-bit hex code. The code is shifted into a 16-bit value register that feeds the CPU and the display path. This is the input-side counterpart of the multiplexed 7-segment display driver: it drives columns one-hot low and reads rows back.

Parameters:
SCAN_DIV, 100000, clk cycles each column is held low (dwell); must be >= 4
DEBOUNCE_SCANS, 4, consecutive identical full scans required to accept a press or a release; must be >= 1

Ports:
clk  input  1  system clock, all logic on posedge
rst  input  1  asynchronous, active-high reset
row_in  input  4  keypad rows, active-low, externally pulled up, asynchronous to clk
clr  input  1  synchronous clear of value
col_out  output  4  keypad column drive, active-low one-hot
key_code  output  4  code of the last accepted key
key_valid  output  1  one-cycle pulse when a key is accepted
value  output  16  hex-digit accumulator, newest digit in [3:0]

Behaviour:
- Reset (async, rst=1): col_out=4'b1110, key_code=0, key_valid=0, value=0, FSM=IDLE, all counters=0, synchronizer flops=4'b1111.
- Sync: row_in passes through a 2-flop synchronizer before use. Only the synchronized value is sampled.
- Dwell counter: counts 0..SCAN_DIV-1 and wraps.
- Sampling: rows are sampled on the cycle the counter equals SCAN_DIV-1. This gives settling time covering the synchronizer delay.
- Column advance: col_out rotates left on the next cycle (1110 -> 1101 -> 1011 -> 0111 -> 1110).
- Scan accumulation: per column sample, count the low rows and remember the (row, col) indices of a low row.
- Full scan completes at the column-3 sample and yields a result:
  - NONE: 0 keys low
  - SINGLE(code): exactly 1 key low
  - MULTI: 2 or more keys low
- Code mapping: code = {row_idx[1:0], col_idx[1:0]}. Row 0 is row_in[0]; column 0 is col_out[0].
- FSM, evaluated once per full scan; debounce counter dc:
  - IDLE:
    - SINGLE(c): latch candidate=c, dc=1, go DEBOUNCE. If DEBOUNCE_SCANS=1, accept immediately.
    - NONE or MULTI: stay.
  - DEBOUNCE:
    - SINGLE(candidate): dc++. When dc reaches DEBOUNCE_SCANS, accept and go PRESSED.
    - SINGLE(other code): restart with the new candidate, dc=1.
    - NONE or MULTI: go IDLE, dc=0.
  - PRESSED:
    - NONE: dc++. After DEBOUNCE_SCANS consecutive NONE scans, go IDLE.
    - Any non-NONE scan: dc=0, stay. MULTI and rollover never generate keys.
- Accept (single cycle, the cycle after the column-3 sample): key_valid=1, key_code=candidate, value={value[11:0], candidate}.
- key_valid is exactly one cycle wide per accepted press. Holding a key gives no repeat.
- clr=1: value=0 next cycle.
  - clr and accept in the same cycle: clr wins, value=0. key_valid and key_code still update.
- Latency: press stable at pins -> key_valid at most (DEBOUNCE_SCANS+1)*4*SCAN_DIV+3 cycles.
- Reset mid-scan or mid-debounce aborts immediately to reset values. No key is emitted.
- value wraps naturally: the 5th digit pushes the oldest digit out of [15:12].

Decomposition:
- Shared package:
  - FSM state encoding (IDLE, DEBOUNCE, PRESSED)
  - scan-result encoding (NONE, SINGLE, MULTI)
  - column reset pattern 4'b1110
- One sub-module is natural: sync2, a generic 2-flop synchronizer with width parameter, reused by other board-input blocks.
- The scanner FSM and the shifter stay in keypad_scan.

Test Plan:
All scenarios run with SCAN_DIV=4, DEBOUNCE_SCANS=2.
1. Reset: rst pulsed mid-operation -> col_out=1110, value=0000, key_valid=0 immediately, without waiting for a clk edge.
2. Single press: hold row 2 low only while col_out=1101 (code 4'h9) for 4 scans, then release -> exactly one key_valid pulse, key_code=9, value=0x0009. No second pulse for the rest of the hold.
3. Sequence and wrap: press and release keys A,B,C,D,E in turn -> value ends at 0xBCDE with 5 key_valid pulses.
4. Bounce: toggle row 0 on column 0 every other scan for 6 scans -> no key_valid; then hold for 3 scans -> one pulse, key_code=0.
5. Multi-key: codes 1 and 6 held together for 5 scans -> no key_valid. Release 6 and keep 1 held -> one pulse, key_code=1.
6. Clear collision: assert clr in the cycle key_valid fires for code 7 -> key_valid=1, key_code=7, value=0x0000.

Source files
------------

// File: rtl/keypad_scan_pkg.sv
// Shared types and helpers for the 4x4 matrix keypad scanner.
// Holds the FSM and scan-result encodings plus small row-decoding functions.
package keypad_scan_pkg;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_DEBOUNCE = 2'd1,
    ST_PRESSED  = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    RES_NONE   = 2'd0,
    RES_SINGLE = 2'd1,
    RES_MULTI  = 2'd2
  } scan_res_t;

  localparam logic [3:0] COL_RESET = 4'b1110;

  // Rows are active-low, so a 0 bit marks a pressed key on the driven column.
  function automatic logic [2:0] count_low(input logic [3:0] rows_n);
    count_low = 3'd0;
    for (int i = 0; i < 4; i++) begin
      count_low = count_low + {2'b00, ~rows_n[i]};
    end
  endfunction

  function automatic logic [1:0] first_low(input logic [3:0] rows_n);
    first_low = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (!rows_n[i]) begin
        first_low = 2'(i);
      end
    end
  endfunction

endpackage

// File: rtl/sync2.sv
// Generic two-flop synchronizer for asynchronous board inputs.
// RESET_VAL lets active-low inputs come out of reset in their idle state.
module sync2 #(
  parameter int               WIDTH     = 1,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta <= RESET_VAL;
      q    <= RESET_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/keypad_scan.sv
// 4x4 active-low keypad scanner with per-scan debouncing.
// Accepted keys are shifted as hex digits into a 16-bit value register.
module keypad_scan #(
  parameter int SCAN_DIV       = 100000,
  parameter int DEBOUNCE_SCANS = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  row_in,
  input  logic        clr,
  output logic [3:0]  col_out,
  output logic [3:0]  key_code,
  output logic        key_valid,
  output logic [15:0] value
);

  import keypad_scan_pkg::*;

  localparam int                CNT_W     = $clog2(SCAN_DIV);
  localparam int                DC_W      = $clog2(DEBOUNCE_SCANS + 1);
  localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(SCAN_DIV - 1);
  localparam logic [DC_W-1:0]   DC_TARGET = DC_W'(DEBOUNCE_SCANS);

  logic [3:0]       row_sync;
  logic [CNT_W-1:0] dwell_cnt;
  logic [1:0]       col_idx;
  logic [2:0]       acc_cnt;
  logic [3:0]       acc_code;

  logic             sample;
  logic             scan_done;
  logic [2:0]       col_lows;
  logic [2:0]       acc_base;
  logic [2:0]       scan_total;
  logic [3:0]       scan_code;
  scan_res_t        scan_res;
  logic             accept;

  state_t           state;
  logic [DC_W-1:0]  dc;
  logic [3:0]       candidate;

  sync2 #(
    .WIDTH     (4),
    .RESET_VAL (4'b1111)
  ) u_row_sync (
    .clk (clk),
    .rst (rst),
    .d   (row_in),
    .q   (row_sync)
  );

  // The scan result folds in the column being sampled right now, so the FSM
  // can act on the column-3 sample edge itself.
  always_comb begin
    sample     = (dwell_cnt == CNT_LAST);
    scan_done  = sample && (col_idx == 2'd3);
    col_lows   = count_low(row_sync);
    acc_base   = (col_idx == 2'd0) ? 3'd0 : acc_cnt;
    scan_total = acc_base + col_lows;
    scan_code  = acc_code;
    if (col_lows != 3'd0) begin
      scan_code = {first_low(row_sync), col_idx};
    end
    if (scan_total == 3'd0) begin
      scan_res = RES_NONE;
    end else if (scan_total == 3'd1) begin
      scan_res = RES_SINGLE;
    end else begin
      scan_res = RES_MULTI;
    end
  end

  always_comb begin
    accept = 1'b0;
    if (scan_done && scan_res == RES_SINGLE) begin
      if (state == ST_IDLE && DEBOUNCE_SCANS == 1) begin
        accept = 1'b1;
      end else if (state == ST_DEBOUNCE && scan_code == candidate &&
                   (dc + DC_W'(1)) == DC_TARGET) begin
        accept = 1'b1;
      end
    end
  end

  // Dwell timing, column drive and per-scan accumulation of low rows.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dwell_cnt <= '0;
      col_out   <= COL_RESET;
      col_idx   <= 2'd0;
      acc_cnt   <= 3'd0;
      acc_code  <= 4'd0;
    end else if (sample) begin
      dwell_cnt <= '0;
      col_out   <= {col_out[2:0], col_out[3]};
      col_idx   <= col_idx + 2'd1;
      acc_cnt   <= (scan_total > 3'd2) ? 3'd2 : scan_total;
      acc_code  <= scan_code;
    end else begin
      dwell_cnt <= dwell_cnt + CNT_W'(1);
    end
  end

  // Debounce FSM plus the registered key outputs and value shifter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      dc        <= '0;
      candidate <= 4'd0;
      key_valid <= 1'b0;
      key_code  <= 4'd0;
      value     <= 16'h0000;
    end else begin
      key_valid <= accept;
      if (accept) begin
        key_code <= scan_code;
      end
      if (clr) begin
        value <= 16'h0000;
      end else if (accept) begin
        value <= {value[11:0], scan_code};
      end

      if (scan_done) begin
        case (state)
          ST_IDLE: begin
            if (scan_res == RES_SINGLE) begin
              candidate <= scan_code;
              if (accept) begin
                state <= ST_PRESSED;
                dc    <= '0;
              end else begin
                state <= ST_DEBOUNCE;
                dc    <= DC_W'(1);
              end
            end
          end
          ST_DEBOUNCE: begin
            if (scan_res == RES_SINGLE) begin
              if (scan_code == candidate) begin
                if (accept) begin
                  state <= ST_PRESSED;
                  dc    <= '0;
                end else begin
                  dc <= dc + DC_W'(1);
                end
              end else begin
                candidate <= scan_code;
                dc        <= DC_W'(1);
              end
            end else begin
              state <= ST_IDLE;
              dc    <= '0;
            end
          end
          ST_PRESSED: begin
            if (scan_res == RES_NONE) begin
              if ((dc + DC_W'(1)) == DC_TARGET) begin
                state <= ST_IDLE;
                dc    <= '0;
              end else begin
                dc <= dc + DC_W'(1);
              end
            end else begin
              dc <= '0;
            end
          end
          default: begin
            state <= ST_IDLE;
            dc    <= '0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_keypad_scan.sv
// Scoreboard bench for keypad_scan: a keypad model drives rows from col_out,
// expected key events are queued by stimulus and popped by a monitor.
module tb_keypad_scan;

  localparam int SCAN_DIV       = 4;
  localparam int DEBOUNCE_SCANS = 2;
  localparam int SCAN_CYCLES    = 4 * SCAN_DIV;

  typedef struct packed {
    logic [3:0]  code;
    logic [15:0] value;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        clr;
  logic [3:0]  row_in;
  logic [3:0]  col_out;
  logic [3:0]  key_code;
  logic        key_valid;
  logic [15:0] value;

  logic [15:0] pressed;
  logic [15:0] exp_value;
  exp_t        exp_q[$];
  int          vectors = 0;
  int          miscompares = 0;

  keypad_scan #(
    .SCAN_DIV       (SCAN_DIV),
    .DEBOUNCE_SCANS (DEBOUNCE_SCANS)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .row_in    (row_in),
    .clr       (clr),
    .col_out   (col_out),
    .key_code  (key_code),
    .key_valid (key_valid),
    .value     (value)
  );

  always #5 clk = ~clk;

  // Physical keypad: a pressed key at (r,c) pulls row r low while column c is driven low.
  always_comb begin
    row_in = 4'b1111;
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        if (pressed[r*4+c] && !col_out[c]) begin
          row_in[r] = 1'b0;
        end
      end
    end
  end

  task automatic checkOutput(input string name, input logic [15:0] actual,
                             input logic [15:0] expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
    end
  endtask

  task automatic expectKey(input logic [3:0] code, input logic cleared);
    exp_t e;
    exp_value = cleared ? 16'h0000 : {exp_value[11:0], code};
    e.code    = code;
    e.value   = exp_value;
    exp_q.push_back(e);
  endtask

  task automatic applyStimulus(input logic [15:0] keys, input int scans);
    pressed = keys;
    repeat (scans * SCAN_CYCLES) @(posedge clk);
    #1;
  endtask

  task automatic drainCheck(input string name);
    checkOutput(name, 16'(exp_q.size()), 16'h0000);
    exp_q.delete();
  endtask

  // Pulses clr during the column-3 sample cycle, i.e. the cycle whose edge accepts a key.
  task automatic pulseClr();
    logic [3:0] prev;
    int         guard;
    prev  = col_out;
    guard = 0;
    @(posedge clk);
    #1;
    while (!(col_out == 4'b0111 && prev != 4'b0111) && guard < 64) begin
      prev = col_out;
      @(posedge clk);
      #1;
      guard++;
    end
    if (guard >= 64) begin
      vectors++;
      miscompares++;
      $display("[TB] FAIL clr_align: col_out stuck at %b, required 0111 within 64 cycles", col_out);
    end else begin
      repeat (SCAN_DIV - 1) @(posedge clk);
      #1;
      clr = 1'b1;
      @(posedge clk);
      #1;
      clr = 1'b0;
    end
  endtask

  always @(negedge clk) begin
    if (!rst && key_valid) begin
      if (exp_q.size() == 0) begin
        vectors++;
        miscompares++;
        $display("[TB] FAIL unexpected_key_valid: got pulse with key_code %h, expected none", key_code);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        checkOutput("key_code", {12'h000, key_code}, {12'h000, e.code});
        checkOutput("value", value, e.value);
      end
    end
  end

  initial begin
    rst       = 1'b1;
    clr       = 1'b0;
    pressed   = 16'h0000;
    exp_value = 16'h0000;
    #2;
    checkOutput("reset_col_out", {12'h000, col_out}, 16'h000e);
    checkOutput("reset_value", value, 16'h0000);
    checkOutput("reset_key_valid", {15'h0, key_valid}, 16'h0000);
    checkOutput("reset_key_code", {12'h000, key_code}, 16'h0000);
    @(negedge clk);
    rst = 1'b0;

    $display("[TB] single press of key 9");
    expectKey(4'h9, 1'b0);
    applyStimulus(16'h1 << 9, 4);
    applyStimulus(16'h0000, 4);
    drainCheck("single_drain");

    $display("[TB] sequence A..E with wrap");
    for (int k = 10; k <= 14; k++) begin
      expectKey(4'(k), 1'b0);
      applyStimulus(16'h1 << k, 4);
      applyStimulus(16'h0000, 4);
    end
    drainCheck("sequence_drain");
    checkOutput("sequence_value", value, 16'hBCDE);

    $display("[TB] reset mid-debounce");
    pressed = 16'h1 << 5;
    repeat (20) @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    checkOutput("midreset_col_out", {12'h000, col_out}, 16'h000e);
    checkOutput("midreset_value", value, 16'h0000);
    checkOutput("midreset_key_valid", {15'h0, key_valid}, 16'h0000);
    checkOutput("midreset_key_code", {12'h000, key_code}, 16'h0000);
    pressed   = 16'h0000;
    exp_value = 16'h0000;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    applyStimulus(16'h0000, 2);
    drainCheck("midreset_drain");

    $display("[TB] bounce on key 0");
    repeat (3) begin
      applyStimulus(16'h0001, 1);
      applyStimulus(16'h0000, 1);
    end
    expectKey(4'h0, 1'b0);
    applyStimulus(16'h0001, 3);
    applyStimulus(16'h0000, 4);
    drainCheck("bounce_drain");

    $display("[TB] multi-key 1+6 then 1 alone");
    applyStimulus((16'h1 << 1) | (16'h1 << 6), 5);
    expectKey(4'h1, 1'b0);
    applyStimulus(16'h1 << 1, 4);
    applyStimulus(16'h0000, 4);
    drainCheck("multi_drain");
    checkOutput("multi_value", value, 16'h0001);

    $display("[TB] clr colliding with accept of key 7");
    expectKey(4'h7, 1'b1);
    fork
      applyStimulus(16'h1 << 7, 4);
      repeat (4) pulseClr();
    join
    applyStimulus(16'h0000, 4);
    drainCheck("clr_drain");
    checkOutput("clr_value", value, 16'h0000);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
